// File: rtl/fft_output_streamer.sv
// Reads one finished 8-point FFT frame from the buffer read port and streams
// it out over valid/ready, un-scrambling bit-reversed storage when enabled.
//
// Handshake: a sample moves on every rising edge where out_valid && out_ready.
// While out_valid=1 and out_ready=0 every out_* signal holds its value.
// out_valid only falls after a transfer, or on reset.
module fft_output_streamer #(
   parameter int ADDR_W      = 3,
   parameter int DATA_W      = 32,
   parameter int BIT_REVERSE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_real,
   input  logic [DATA_W-1:0] rd_imag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_real,
   output logic [DATA_W-1:0] out_imag,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic              load;
   logic              xfer;

   // Mirror of cnt with the bit order flipped across ADDR_W.
   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
      logic [ADDR_W-1:0] r;
      r = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         r[i] = v[ADDR_W-1-i];
      end
      return r;
   endfunction

   // The output register takes a new sample whenever it is empty or draining.
   assign load = (state == STREAM) && (!out_valid || out_ready);
   assign xfer = out_valid && out_ready;
   assign dbg_state = state;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, busy and read address; the buffer is addressed only in STREAM.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      rd_addr   = '0;
      case (state)
         IDLE: begin
            if (start) state_nxt = STREAM;
         end
         STREAM: begin
            busy    = 1'b1;
            rd_addr = (BIT_REVERSE != 0) ? bitrev(cnt) : cnt;
            if (load && (cnt == LAST_IDX)) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (xfer) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output index counter: cleared on an accepted start, stepped on each load.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if ((state == IDLE) && start) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Output sample register plus the one-cycle done pulse after the final accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_real  <= '0;
         out_imag  <= '0;
         out_index <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            out_real  <= rd_real;
            out_imag  <= rd_imag;
            out_index <= cnt;
            out_last  <= (cnt == LAST_IDX);
            out_valid <= 1'b1;
         end else if ((state == DRAIN) && xfer) begin
            // Data fields keep the last sample after the frame ends.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_output_streamer.sv
// Bench for fft_output_streamer: one instance with bit-reversed reads, one
// with natural-order reads, both reading the same modelled buffer.
module tb_fft_output_streamer;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;
   localparam int N      = 1 << ADDR_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- buffer model ----------------
   logic [DATA_W-1:0] mem_real [N];
   logic [DATA_W-1:0] mem_imag [N];

   // DUT 1: BIT_REVERSE=1, DUT 0: BIT_REVERSE=0
   logic              start1 = 1'b0, start0 = 1'b0;
   logic              ready1 = 1'b0, ready0 = 1'b0;
   logic              busy1, busy0, done1, done0;
   logic [ADDR_W-1:0] rd_addr1, rd_addr0;
   logic [DATA_W-1:0] rd_real1, rd_imag1, rd_real0, rd_imag0;
   logic              valid1, valid0, last1, last0;
   logic [DATA_W-1:0] oreal1, oimag1, oreal0, oimag0;
   logic [ADDR_W-1:0] oidx1, oidx0;
   logic [1:0]        dbg1, dbg0;

   assign rd_real1 = mem_real[rd_addr1];
   assign rd_imag1 = mem_imag[rd_addr1];
   assign rd_real0 = mem_real[rd_addr0];
   assign rd_imag0 = mem_imag[rd_addr0];

   fft_output_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BIT_REVERSE(1)) dut_rev (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .rd_addr(rd_addr1), .rd_real(rd_real1), .rd_imag(rd_imag1),
      .out_valid(valid1), .out_ready(ready1), .out_real(oreal1), .out_imag(oimag1),
      .out_index(oidx1), .out_last(last1), .dbg_state(dbg1)
   );

   fft_output_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BIT_REVERSE(0)) dut_nat (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
      .rd_addr(rd_addr0), .rd_real(rd_real0), .rd_imag(rd_imag0),
      .out_valid(valid0), .out_ready(ready0), .out_real(oreal0), .out_imag(oimag0),
      .out_index(oidx0), .out_last(last0), .dbg_state(dbg0)
   );

   // Selected instance, observed through one set of names.
   int                cur_sel = 1;
   logic              o_busy, o_done, o_valid, o_last;
   logic [ADDR_W-1:0] o_addr, o_idx;
   logic [DATA_W-1:0] o_real, o_imag;
   assign o_busy  = cur_sel != 0 ? busy1    : busy0;
   assign o_done  = cur_sel != 0 ? done1    : done0;
   assign o_valid = cur_sel != 0 ? valid1   : valid0;
   assign o_last  = cur_sel != 0 ? last1    : last0;
   assign o_addr  = cur_sel != 0 ? rd_addr1 : rd_addr0;
   assign o_idx   = cur_sel != 0 ? oidx1    : oidx0;
   assign o_real  = cur_sel != 0 ? oreal1   : oreal0;
   assign o_imag  = cur_sel != 0 ? oimag1   : oimag0;

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] exp_real_q [$];
   logic [DATA_W-1:0] exp_imag_q [$];
   logic [ADDR_W-1:0] exp_idx_q  [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bit reversal computed arithmetically: peel low digits, push them high.
   function automatic int bitrev_ref(input int k);
      int r = 0;
      int v = k;
      for (int i = 0; i < ADDR_W; i++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   task automatic fill_pattern();
      for (int a = 0; a < N; a++) begin
         mem_real[a] = a * 32'h11;
         mem_imag[a] = ~(a * 32'h11);
      end
   endtask

   task automatic fill_random();
      for (int a = 0; a < N; a++) begin
         mem_real[a] = $urandom;
         mem_imag[a] = $urandom;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_start(input logic v);
      if (cur_sel != 0) start1 = v; else start0 = v;
   endtask

   task automatic drive_ready(input logic v);
      if (cur_sel != 0) ready1 = v; else ready0 = v;
   endtask

   // Streams one frame from the selected instance and checks it.
   //   rnd       : random 50% out_ready (else held high)
   //   stall_idx : hold out_ready low 5 cycles when this index is first presented
   //   start_idx : pulse start while this index is presented (must be ignored)
   //   rst_idx   : assert reset right after this index is accepted
   //   want_busy : expected busy cycle count, 0 = not checked
   task automatic run_frame(input int sel, input int rnd, input int stall_idx,
                            input int start_idx, input int rst_idx, input int want_busy);
      logic [DATA_W-1:0] pr, pi;
      logic [ADDR_W-1:0] px;
      logic              pl, r, xfer, hold, done_due, rst_pend, finished;
      int stall_left, busy_cycles, first_x, last_x, nxfer;
      bit stall_used, start_used;
      logic [DATA_W-1:0] last_real;

      cur_sel = sel;
      exp_real_q.delete(); exp_imag_q.delete(); exp_idx_q.delete();
      for (int k = 0; k < N; k++) begin
         int a;
         a = (sel != 0) ? bitrev_ref(k) : k;
         exp_real_q.push_back(mem_real[a]);
         exp_imag_q.push_back(mem_imag[a]);
         exp_idx_q.push_back(k[ADDR_W-1:0]);
      end
      last_real = exp_real_q[N-1];

      @(negedge clk);
      chk("idle_busy", {63'd0, o_busy}, 64'd0);
      chk("idle_addr", {61'd0, o_addr}, 64'd0);
      drive_ready(1'b1);
      drive_start(1'b1);
      @(negedge clk);
      drive_start(1'b0);
      busy_cycles = o_busy ? 1 : 0;
      chk("start_busy", {63'd0, o_busy}, 64'd1);
      chk("start_valid_lat", {63'd0, o_valid}, 64'd0);

      stall_left = 0; stall_used = 0; start_used = 0;
      first_x = -1; last_x = -1; nxfer = 0;
      rst_pend = 0; finished = 0;
      for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
         if (rst_pend) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rst_valid", {63'd0, o_valid}, 64'd0);
            chk("rst_busy",  {63'd0, o_busy},  64'd0);
            chk("rst_addr",  {61'd0, o_addr},  64'd0);
            chk("rst_done",  {63'd0, o_done},  64'd0);
            rst = 1'b0;
            exp_real_q.delete(); exp_imag_q.delete(); exp_idx_q.delete();
            finished = 1;
         end else begin
            r = rnd != 0 ? logic'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && (int'(o_idx) == stall_idx) && !stall_used) begin
               stall_left = 5;
               stall_used = 1;
            end
            if (stall_left > 0) begin
               r = 1'b0;
               stall_left--;
            end
            drive_ready(r);
            if (o_valid && (int'(o_idx) == start_idx) && !start_used) begin
               drive_start(1'b1);
               start_used = 1;
            end else begin
               drive_start(1'b0);
            end
            xfer = o_valid && r;
            if (xfer) begin
               if (exp_idx_q.size() == 0) begin
                  chk("extra_sample", {61'd0, o_idx}, 64'hFFFF);
               end else begin
                  logic [ADDR_W-1:0] ei;
                  ei = exp_idx_q.pop_front();
                  chk("out_index", {61'd0, o_idx}, {61'd0, ei});
                  chk("out_real", {32'd0, o_real}, {32'd0, exp_real_q.pop_front()});
                  chk("out_imag", {32'd0, o_imag}, {32'd0, exp_imag_q.pop_front()});
                  chk("out_last", {63'd0, o_last}, {63'd0, (int'(ei) == N-1)});
                  if (int'(ei) == rst_idx) rst_pend = 1;
               end
               nxfer++;
               if (first_x < 0) first_x = cyc;
               last_x = cyc;
            end
            hold = o_valid && !r;
            pr = o_real; pi = o_imag; px = o_idx; pl = o_last;
            done_due = xfer && (exp_idx_q.size() == 0) && !rst_pend;
            @(negedge clk);
            drive_start(1'b0);
            if (o_busy) busy_cycles++;
            if (hold) begin
               chk("hold_valid", {63'd0, o_valid}, 64'd1);
               chk("hold_data", {o_real, o_imag}, {pr, pi});
               chk("hold_idx_last", {60'd0, o_idx, o_last}, {60'd0, px, pl});
            end
            chk("done", {63'd0, o_done}, {63'd0, done_due});
            if (done_due) begin
               chk("end_busy",  {63'd0, o_busy},  64'd0);
               chk("end_valid", {63'd0, o_valid}, 64'd0);
               chk("end_last",  {63'd0, o_last},  64'd0);
               chk("end_real_kept", {32'd0, o_real}, {32'd0, last_real});
               chk("sample_count", nxfer, N);
               finished = 1;
            end else begin
               chk("busy_mid", {63'd0, o_busy}, 64'd1);
            end
         end
      end
      if (!finished) chk("timeout", 64'd0, 64'd1);
      if (want_busy > 0 && rst_idx < 0) begin
         chk("busy_cycles", busy_cycles, want_busy);
         chk("back_to_back", last_x - first_x, N - 1);
      end
      // A quiet gap: no stray frame, no second done.
      drive_ready(1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("quiet_valid", {63'd0, o_valid}, 64'd0);
         chk("quiet_done",  {63'd0, o_done},  64'd0);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      fill_pattern();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy1",  {63'd0, busy1},  64'd0);
      chk("rst_valid1", {63'd0, valid1}, 64'd0);
      chk("rst_done1",  {63'd0, done1},  64'd0);
      chk("rst_last1",  {63'd0, last1},  64'd0);
      chk("rst_addr1",  {61'd0, rd_addr1}, 64'd0);
      chk("rst_data1",  {oreal1, oimag1}, 64'd0);
      chk("rst_idx1",   {61'd0, oidx1}, 64'd0);
      chk("rst_valid0", {63'd0, valid0}, 64'd0);
      chk("rst_busy0",  {63'd0, busy0},  64'd0);
      rst = 1'b0;

      run_frame(1, 0, -1, -1, -1, N + 1);   // bit-reversed order, full rate
      run_frame(0, 0, -1, -1, -1, N + 1);   // natural order, full rate
      fill_random();
      run_frame(1, 1, 3, -1, -1, 0);        // random backpressure + stall at 3
      run_frame(1, 0, 7, -1, -1, 0);        // stall on the final sample
      run_frame(1, 1, -1, 2, -1, 0);        // start while busy is ignored
      run_frame(1, 0, -1, -1, 4, 0);        // reset mid-frame
      run_frame(1, 1, -1, -1, -1, 0);       // full frame after reset
      for (int f = 0; f < 4; f++) begin
         fill_random();
         run_frame(f % 2, 1, $urandom_range(0, N - 1), -1, -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
